enemy_projectile_controller: RTL and testbench
==============================================

Name: enemy_projectile_controller

Overview:
- Producer side of the player-hit interface. Spawns, moves and retires up to three enemy projectiles.
- Tests each projectile against the player rectangle and issues the single-cycle playerHit pulse that the player controller consumes.
- Sits between the enemy/alien logic (fire requests) and the player controller. Also drives projectile coordinates to the VGA renderer.

Parameters:
- PLAYER_Y, 440, fixed top Y of the player sprite
- PLAYER_W, 32, player width in pixels
- PLAYER_H, 16, player height in pixels
- PROJ_W, 4, projectile width in pixels
- PROJ_H, 8, projectile height in pixels
- PROJ_STEP, 4, downward pixels moved per pulse_stepCycle
- SCREEN_H, 480, projectile is retired when its Y is >= this value
- INVULN_STEPS, 30, step pulses of invulnerability after a hit (optional feature only)

Ports:
- clk_master  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pulse_stepCycle  in  1  one-cycle game-tick strobe
- fire_req  in  1  one-cycle request to spawn a projectile
- fire_x  in  10  spawn X
- fire_y  in  9  spawn Y
- playerX  in  10  current player left X
- proj1X, proj2X, proj3X  out  10  projectile X per slot
- proj1Y, proj2Y, proj3Y  out  9  projectile Y per slot
- projActive  out  3  slot valid bits; bit0 is slot 1
- playerHit  out  1  one-cycle hit pulse
- fire_drop  out  1  one-cycle pulse when a request is discarded

Behaviour:
- Reset (async, rst_n=0): all outputs 0, all slots inactive, pending fire cleared, FSM in IDLE.
- FSM states: IDLE, MOVE, CHECK.
  - IDLE -> MOVE on pulse_stepCycle.
  - MOVE -> CHECK unconditionally.
  - CHECK -> IDLE unconditionally.
  - pulse_stepCycle seen in MOVE or CHECK is ignored.
- Step latency: pulse sampled at edge T.
  - Positions update at T+1.
  - playerHit is asserted during the cycle after edge T+2, and the hit slot is cleared at edge T+2.
- MOVE:
  - Each active slot: Y <= Y + PROJ_STEP, computed at 10 bits.
  - If the 10-bit sum is >= SCREEN_H, the slot goes inactive and its X/Y are zeroed.
  - No hit is reported for a projectile retired this way.
- CHECK: overlap test per active slot, using 11-bit unsigned arithmetic throughout. A hit requires all four:
  - projX < playerX+PLAYER_W
  - projX+PROJ_W > playerX
  - projY < PLAYER_Y+PLAYER_H
  - projY+PROJ_H > PLAYER_Y
- Each overlapping slot is deactivated. If one or more slots hit, a single playerHit pulse is issued (no multi-pulse).
- Fire handling:
  - fire_req in IDLE with no pulse_stepCycle: load the lowest-index inactive slot at the next edge.
  - fire_req in MOVE/CHECK, or coincident with pulse_stepCycle: latch into a one-deep pending register (fire_x/fire_y captured). Service it on the first IDLE cycle. The spawned projectile does not move on that step.
  - A second request while pending is full: new request dropped, fire_drop pulses.
  - All three slots busy when servicing: request dropped, fire_drop pulses, pending cleared.
- A freshly spawned projectile is not collision-checked until the next CHECK.
- fire_y >= SCREEN_H at spawn: the slot is loaded; it retires at the next MOVE.
- Reset mid-step: the FSM returns to IDLE immediately and no playerHit is issued.

Optional Feature:
- Macro: PROJ_INVULN_EN.
- Defined:
  - After a playerHit, an invulnerability counter loads INVULN_STEPS.
  - The counter decrements once per MOVE until 0.
  - While nonzero, overlapping projectiles are still deactivated in CHECK but playerHit is suppressed.
  - The counter is reset to 0.
- Undefined: no counter; every CHECK with an overlap pulses playerHit.

Test Plan:
- Reset, then fire_req with fire_x=100, fire_y=400 -> projActive=3'b001, proj1X=100, proj1Y=400. All other outputs 0.
- Same projectile, playerX=98, 9 step pulses -> proj1Y reaches 436 on the 9th MOVE. playerHit is a single one-cycle pulse 2 cycles after that pulse. projActive returns to 0.
- Projectile at x=300, playerX=0, fire_y=470, 3 steps -> retired at the 3rd MOVE (478+4=482>=480). No playerHit.
- Four fire_req in separate IDLE cycles -> slots 1..3 filled; the 4th produces fire_drop=1 for one cycle.
- fire_req coincident with pulse_stepCycle (fire_y=100) -> slot loaded 3 cycles later with Y=100, unmoved.
- Two slots overlapping in the same CHECK -> exactly one playerHit pulse, both slots cleared.
- With PROJ_INVULN_EN: a second overlap 5 steps after a hit -> slot cleared, no playerHit.
- With PROJ_INVULN_EN: an overlap after 30 steps -> playerHit pulses.

Source files
------------

// File: rtl/enemy_projectile_controller.sv
// Enemy projectile spawner/mover with player-hit detection (three slots).
// Optional PROJ_INVULN_EN: post-hit invulnerability window in step pulses.
module enemy_projectile_controller #(
    parameter int PLAYER_Y  = 440,
    parameter int PLAYER_W  = 32,
    parameter int PLAYER_H  = 16,
    parameter int PROJ_W    = 4,
    parameter int PROJ_H    = 8,
    parameter int PROJ_STEP = 4,
    parameter int SCREEN_H  = 480
`ifdef PROJ_INVULN_EN
    ,
    parameter int INVULN_STEPS = 30
`endif
) (
    input  logic       clk_master,
    input  logic       rst_n,
    input  logic       pulse_stepCycle,
    input  logic       fire_req,
    input  logic [9:0] fire_x,
    input  logic [8:0] fire_y,
    input  logic [9:0] playerX,
    output logic [9:0] proj1X,
    output logic [9:0] proj2X,
    output logic [9:0] proj3X,
    output logic [8:0] proj1Y,
    output logic [8:0] proj2Y,
    output logic [8:0] proj3Y,
    output logic [2:0] projActive,
    output logic       playerHit,
    output logic       fire_drop
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MOVE  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam logic [10:0] PLW  = 11'(PLAYER_W);
    localparam logic [10:0] PRW  = 11'(PROJ_W);
    localparam logic [10:0] PRH  = 11'(PROJ_H);
    localparam logic [10:0] PTOP = 11'(PLAYER_Y);
    localparam logic [10:0] PBOT = 11'(PLAYER_Y + PLAYER_H);
    localparam logic [9:0]  STEP = 10'(PROJ_STEP);
    localparam logic [9:0]  SCR  = 10'(SCREEN_H);

    logic [1:0] state;
    logic [9:0] px [3];
    logic [8:0] py [3];
    logic [2:0] act;

    logic       pend_v;
    logic [9:0] pend_x;
    logic [8:0] pend_y;

    logic       idle;
    logic       direct;
    logic       need_pend;
    logic       pend_take;
    logic       do_load;
    logic       any_free;
    logic       drop;
    logic       hit_any;
    logic       hit_pulse;
    logic [1:0] free_idx;
    logic [9:0] ld_x;
    logic [8:0] ld_y;
    logic [9:0] ysum [3];
    logic [2:0] hit;
    logic [10:0] pl_lo;
    logic [10:0] pl_hi;

    function automatic logic overlap(input logic [9:0]  x,
                                     input logic [8:0]  y,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
        logic [10:0] x11;
        logic [10:0] y11;
        x11 = {1'b0, x};
        y11 = {2'b0, y};
        return (x11 < hi) && ((x11 + PRW) > lo) &&
               (y11 < PBOT) && ((y11 + PRH) > PTOP);
    endfunction

    assign idle      = (state == IDLE);
    // A request that cannot load now goes to the one-deep pending buffer,
    // which is always freed during an IDLE cycle.
    assign direct    = idle && fire_req && !pulse_stepCycle && !pend_v;
    assign need_pend = fire_req && !direct;
    assign pend_take = need_pend && (!pend_v || idle);
    assign do_load   = idle && (pend_v || direct);
    assign ld_x      = pend_v ? pend_x : fire_x;
    assign ld_y      = pend_v ? pend_y : fire_y;
    assign drop      = (do_load && !any_free) || (need_pend && !pend_take);

    always_comb begin
        free_idx = 2'd0;
        any_free = 1'b1;
        if (!act[0])      free_idx = 2'd0;
        else if (!act[1]) free_idx = 2'd1;
        else if (!act[2]) free_idx = 2'd2;
        else              any_free = 1'b0;
    end

    assign pl_lo = {1'b0, playerX};
    assign pl_hi = pl_lo + PLW;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ysum[i] = {1'b0, py[i]} + STEP;
            hit[i]  = act[i] && overlap(px[i], py[i], pl_lo, pl_hi);
        end
    end

    assign hit_any = (state == CHECK) && (|hit);

`ifdef PROJ_INVULN_EN
    logic [7:0] inv_cnt;

    assign hit_pulse = hit_any && (inv_cnt == 8'd0);

    always_ff @(posedge clk_master or negedge rst_n) begin
        if (!rst_n) begin
            inv_cnt <= 8'd0;
        end else if (hit_pulse) begin
            inv_cnt <= 8'(INVULN_STEPS);
        end else if (state == MOVE && inv_cnt != 8'd0) begin
            inv_cnt <= inv_cnt - 8'd1;
        end
    end
`else
    assign hit_pulse = hit_any;
`endif

    always_ff @(posedge clk_master or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            act       <= 3'b000;
            pend_v    <= 1'b0;
            pend_x    <= 10'd0;
            pend_y    <= 9'd0;
            playerHit <= 1'b0;
            fire_drop <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                px[i] <= 10'd0;
                py[i] <= 9'd0;
            end
        end else begin
            playerHit <= hit_pulse;
            fire_drop <= drop;
            if (pend_take) begin
                pend_v <= 1'b1;
                pend_x <= fire_x;
                pend_y <= fire_y;
            end else if (idle && pend_v) begin
                pend_v <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (pulse_stepCycle) state <= MOVE;
                    if (do_load && any_free) begin
                        act[free_idx] <= 1'b1;
                        px[free_idx]  <= ld_x;
                        py[free_idx]  <= ld_y;
                    end
                end
                MOVE: begin
                    state <= CHECK;
                    for (int i = 0; i < 3; i++) begin
                        if (act[i]) begin
                            if (ysum[i] >= SCR) begin
                                act[i] <= 1'b0;
                                px[i]  <= 10'd0;
                                py[i]  <= 9'd0;
                            end else begin
                                py[i] <= ysum[i][8:0];
                            end
                        end
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    for (int i = 0; i < 3; i++) begin
                        if (hit[i]) begin
                            act[i] <= 1'b0;
                            px[i]  <= 10'd0;
                            py[i]  <= 9'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign proj1X     = px[0];
    assign proj2X     = px[1];
    assign proj3X     = px[2];
    assign proj1Y     = py[0];
    assign proj2Y     = py[1];
    assign proj3Y     = py[2];
    assign projActive = act;

endmodule

// File: tb/tb_enemy_projectile_controller.sv
// Randomized + directed bench for enemy_projectile_controller.
// Reference model tracks projectiles as plain integers per game rules.
module tb_enemy_projectile_controller;

    localparam int P_Y  = 440;
    localparam int P_W  = 32;
    localparam int P_H  = 16;
    localparam int J_W  = 4;
    localparam int J_H  = 8;
    localparam int STEP = 4;
    localparam int SCR  = 480;
    localparam int INV  = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pulse = 1'b0;
    logic       req = 1'b0;
    logic [9:0] fx = '0;
    logic [8:0] fy = '0;
    logic [9:0] plx = '0;
    logic [9:0] x1, x2, x3;
    logic [8:0] y1, y2, y3;
    logic [2:0] act;
    logic       hit;
    logic       drop;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int m_act [3];
    int m_x [3];
    int m_y [3];
    int m_pend, m_px, m_py;
    int m_phase;
    int m_hit, m_drop;
    int m_inv;

    enemy_projectile_controller dut (
        .clk_master     (clk),
        .rst_n          (rst_n),
        .pulse_stepCycle(pulse),
        .fire_req       (req),
        .fire_x         (fx),
        .fire_y         (fy),
        .playerX        (plx),
        .proj1X         (x1),
        .proj2X         (x2),
        .proj3X         (x3),
        .proj1Y         (y1),
        .proj2Y         (y2),
        .proj3Y         (y3),
        .projActive     (act),
        .playerHit      (hit),
        .fire_drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0;
            m_x[i]   = 0;
            m_y[i]   = 0;
        end
        m_pend = 0; m_px = 0; m_py = 0;
        m_phase = 0; m_hit = 0; m_drop = 0; m_inv = 0;
    endtask

    task automatic m_load(input int x, input int y);
        for (int i = 0; i < 3; i++) begin
            if (m_act[i] == 0) begin
                m_act[i] = 1;
                m_x[i]   = x;
                m_y[i]   = y;
                return;
            end
        end
        m_drop = 1;
    endtask

    task automatic m_latch(input bit r, input int x, input int y);
        if (r) begin
            if (m_pend != 0) begin
                m_drop = 1;
            end else begin
                m_pend = 1; m_px = x; m_py = y;
            end
        end
    endtask

    function automatic bit m_overlap(input int x, input int y, input int p);
        return (x < p + P_W) && (x + J_W > p) &&
               (y < P_Y + P_H) && (y + J_H > P_Y);
    endfunction

    // One clock edge of the game rules.
    task automatic m_step(input bit pl, input bit r, input int x,
                          input int y, input int p);
        int nh;
        m_hit = 0;
        m_drop = 0;
        case (m_phase)
            0: begin
                if (m_pend != 0) begin
                    m_pend = 0;
                    m_load(m_px, m_py);
                    if (r) begin m_pend = 1; m_px = x; m_py = y; end
                end else if (r) begin
                    if (pl) begin m_pend = 1; m_px = x; m_py = y; end
                    else m_load(x, y);
                end
                if (pl) m_phase = 1;
            end
            1: begin
                m_latch(r, x, y);
                for (int i = 0; i < 3; i++) begin
                    if (m_act[i] != 0) begin
                        if (m_y[i] + STEP >= SCR) begin
                            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
                        end else begin
                            m_y[i] = m_y[i] + STEP;
                        end
                    end
                end
`ifdef PROJ_INVULN_EN
                if (m_inv > 0) m_inv--;
`endif
                m_phase = 2;
            end
            default: begin
                m_latch(r, x, y);
                nh = 0;
                for (int i = 0; i < 3; i++) begin
                    if (m_act[i] != 0 && m_overlap(m_x[i], m_y[i], p)) begin
                        nh++;
                        m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
                    end
                end
`ifdef PROJ_INVULN_EN
                if (nh > 0 && m_inv == 0) begin
                    m_hit = 1;
                    m_inv = INV;
                end
`else
                if (nh > 0) m_hit = 1;
`endif
                m_phase = 0;
            end
        endcase
    endtask

    task automatic check_all();
        logic [2:0] ea;
        ea = '0;
        for (int i = 0; i < 3; i++) ea[i] = (m_act[i] != 0);
        chk("active", 32'(act), 32'(ea));
        chk("x1", 32'(x1), m_x[0]);
        chk("x2", 32'(x2), m_x[1]);
        chk("x3", 32'(x3), m_x[2]);
        chk("y1", 32'(y1), m_y[0]);
        chk("y2", 32'(y2), m_y[1]);
        chk("y3", 32'(y3), m_y[2]);
        chk("hit", 32'(hit), m_hit);
        chk("drop", 32'(drop), m_drop);
    endtask

    task automatic tick(input bit pl, input bit r, input logic [9:0] x,
                        input logic [8:0] y, input logic [9:0] p);
        pulse = pl; req = r; fx = x; fy = y; plx = p;
        m_step(pl, r, int'(x), int'(y), int'(p));
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic step(input logic [9:0] p);
        tick(1'b1, 1'b0, 10'd0, 9'd0, p);
        tick(1'b0, 1'b0, 10'd0, 9'd0, p);
        tick(1'b0, 1'b0, 10'd0, 9'd0, p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pulse = 1'b0; req = 1'b0;
        m_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_reset();

        // spawn, then walk into the player
        do_reset();
        chk("rst_hit", 32'(hit), 0);
        tick(1'b0, 1'b1, 10'd100, 9'd400, 10'd98);
        chk("spawn_act", 32'(act), 1);
        chk("spawn_x", 32'(x1), 100);
        chk("spawn_y", 32'(y1), 400);
        for (int k = 0; k < 9; k++) begin
            tick(1'b1, 1'b0, 10'd0, 9'd0, 10'd98);
            tick(1'b0, 1'b0, 10'd0, 9'd0, 10'd98);
            if (k == 8) chk("y_436", 32'(y1), 436);
            tick(1'b0, 1'b0, 10'd0, 9'd0, 10'd98);
            if (k == 8) begin
                chk("hit_pulse", 32'(hit), 1);
                chk("hit_clear", 32'(act), 0);
            end
        end
        tick(1'b0, 1'b0, 10'd0, 9'd0, 10'd98);
        chk("hit_once", 32'(hit), 0);

        // retire off the bottom
        do_reset();
        tick(1'b0, 1'b1, 10'd300, 9'd470, 10'd0);
        step(10'd0);
        step(10'd0);
        chk("y_478", 32'(y1), 478);
        step(10'd0);
        chk("retired", 32'(act), 0);

        // four requests, three slots
        do_reset();
        for (int k = 0; k < 4; k++)
            tick(1'b0, 1'b1, 10'(20 * k), 9'd100, 10'd0);
        chk("drop_4th", 32'(drop), 1);
        tick(1'b0, 1'b0, 10'd0, 9'd0, 10'd0);
        chk("drop_once", 32'(drop), 0);
        chk("full", 32'(act), 7);

        // request coincident with step pulse
        do_reset();
        tick(1'b1, 1'b1, 10'd50, 9'd100, 10'd0);
        tick(1'b0, 1'b0, 10'd0, 9'd0, 10'd0);
        tick(1'b0, 1'b0, 10'd0, 9'd0, 10'd0);
        chk("pend_wait", 32'(act), 0);
        tick(1'b0, 1'b0, 10'd0, 9'd0, 10'd0);
        chk("pend_load", 32'(act), 1);
        chk("pend_y", 32'(y1), 100);

        // double overlap -> one pulse
        do_reset();
        tick(1'b0, 1'b1, 10'd100, 9'd436, 10'd98);
        tick(1'b0, 1'b1, 10'd110, 9'd436, 10'd98);
        step(10'd98);
        chk("dbl_hit", 32'(hit), 1);
        chk("dbl_clear", 32'(act), 0);
        tick(1'b0, 1'b0, 10'd0, 9'd0, 10'd98);
        chk("dbl_once", 32'(hit), 0);

        // overlap 5 steps and 30 steps after that hit
        for (int k = 0; k < 4; k++) step(10'd98);
        tick(1'b0, 1'b1, 10'd100, 9'd436, 10'd98);
        step(10'd98);
`ifdef PROJ_INVULN_EN
        chk("inv_block", 32'(hit), 0);
`else
        chk("inv_block", 32'(hit), 1);
`endif
        chk("inv_clear", 32'(act), 0);
        for (int k = 0; k < 24; k++) step(10'd98);
        tick(1'b0, 1'b1, 10'd100, 9'd436, 10'd98);
        step(10'd98);
        chk("inv_expire", 32'(hit), 1);

        // random traffic with occasional mid-step resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [9:0] p;
            logic [9:0] x;
            logic [8:0] y;
            if (c % 300 == 0) plx = 10'($urandom_range(0, 600));
            p = plx;
            x = p + 10'($urandom_range(0, 44)) - 10'd6;
            if ($urandom_range(0, 9) == 0) y = 9'($urandom);
            else y = 9'($urandom_range(380, 470));
            if ($urandom_range(0, 249) == 0) begin
                rst_n = 1'b0;
                pulse = 1'b0; req = 1'b0;
                m_reset();
                #1;
                check_all();
                rst_n = 1'b1;
            end
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 x, y, p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
